// File: rtl/adc_read_pkg.sv
// ============================================================================
// Package     : adc_read_pkg
// Description : State encodings, ADS1115 pointer values and default settings
//               shared by the ADC read sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package adc_read_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_CFG_START  = 3'd0;
  localparam state_t ST_CFG_WAIT   = 3'd1;
  localparam state_t ST_PTR_START  = 3'd2;
  localparam state_t ST_PTR_WAIT   = 3'd3;
  localparam state_t ST_CONV_DELAY = 3'd4;
  localparam state_t ST_RD_START   = 3'd5;
  localparam state_t ST_RD_WAIT    = 3'd6;

  localparam logic [7:0] PTR_CONV = 8'h00;
  localparam logic [7:0] PTR_CFG  = 8'h01;

  localparam logic [6:0]  DEFAULT_SLAVE_ADDR       = 7'h48;
  localparam logic [15:0] DEFAULT_CONFIG_WORD      = 16'h8483;
  localparam int          DEFAULT_CONV_WAIT_CYCLES = 1_000_000;

endpackage

`default_nettype wire

// File: rtl/delay_counter.sv
// ============================================================================
// Module      : delay_counter
// Description : Loadable down-counter with a zero flag; load wins over dec.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module delay_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             dec,
  output logic             zero
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_value;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

`default_nettype wire

// File: rtl/adc_i2c_read_fsm.sv
// ============================================================================
// Module      : adc_i2c_read_fsm
// Description : Configures an ADS1115-class ADC over a byte-oriented I2C master
//               and then reads one signed 16-bit conversion per period.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module adc_i2c_read_fsm
  import adc_read_pkg::*;
#(
  parameter int          MAX_BYTES_PER_TRANSACTION = 3,
  parameter logic [6:0]  SLAVE_ADDR                = DEFAULT_SLAVE_ADDR,
  parameter logic [15:0] CONFIG_WORD               = DEFAULT_CONFIG_WORD,
  parameter int          CONV_WAIT_CYCLES          = DEFAULT_CONV_WAIT_CYCLES
) (
  input  logic                                         clk,
  input  logic                                         reset,
  input  logic                                         i2c_transaction_done,
  input  logic [7:0]                                   i2c_master_dout [0:MAX_BYTES_PER_TRANSACTION-1],
  output logic                                         i2c_transaction_start,
  output logic                                         i2c_transaction_rd_nwr,
  output logic [6:0]                                   i2c_transaction_slave_addr,
  output logic [7:0]                                   i2c_master_din [0:MAX_BYTES_PER_TRANSACTION-1],
  output logic [$clog2(MAX_BYTES_PER_TRANSACTION+1)-1:0] i2c_transaction_bytes_num,
  output logic [15:0]                                  adc_sample,
  output logic                                         adc_sample_valid
);

  localparam int N     = MAX_BYTES_PER_TRANSACTION;
  localparam int BW    = $clog2(N + 1);
  localparam int CNT_W = (CONV_WAIT_CYCLES > 1) ? $clog2(CONV_WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CONV_WAIT_CYCLES - 1);

  if (N < 3) begin : g_bad_max_bytes
    $error("adc_i2c_read_fsm: MAX_BYTES_PER_TRANSACTION must be >= 3");
  end
  if (CONV_WAIT_CYCLES < 1) begin : g_bad_conv_wait
    $error("adc_i2c_read_fsm: CONV_WAIT_CYCLES must be >= 1");
  end

  state_t          state_q, state_d;
  logic            start_q, start_d;
  logic            rd_nwr_q, rd_nwr_d;
  logic [6:0]      addr_q, addr_d;
  logic [7:0]      din_q [0:N-1];
  logic [7:0]      din_d [0:N-1];
  logic [BW-1:0]   bytes_q, bytes_d;
  logic [15:0]     sample_q, sample_d;
  logic            valid_q, valid_d;
  logic            cnt_load;
  logic            cnt_dec;
  logic            cnt_zero;
  logic [7:0]      dout_unused_xor;

  delay_counter #(
    .WIDTH (CNT_W)
  ) u_delay_counter (
    .clk        (clk),
    .reset      (reset),
    .load       (cnt_load),
    .load_value (RELOAD),
    .dec        (cnt_dec),
    .zero       (cnt_zero)
  );

  // Outputs are computed from the current state and registered, so start is
  // visible during the cycle after a *_START state (i.e. while in *_WAIT).
  always_comb begin
    state_d  = state_q;
    start_d  = 1'b0;
    rd_nwr_d = rd_nwr_q;
    addr_d   = addr_q;
    din_d    = din_q;
    bytes_d  = bytes_q;
    sample_d = sample_q;
    valid_d  = 1'b0;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;

    case (state_q)
      ST_CFG_START: begin
        start_d  = 1'b1;
        rd_nwr_d = 1'b0;
        addr_d   = SLAVE_ADDR;
        bytes_d  = BW'(3);
        for (int i = 0; i < N; i++) din_d[i] = 8'h00;
        din_d[0] = PTR_CFG;
        din_d[1] = CONFIG_WORD[15:8];
        din_d[2] = CONFIG_WORD[7:0];
        state_d  = ST_CFG_WAIT;
      end
      ST_CFG_WAIT: begin
        if (i2c_transaction_done) state_d = ST_PTR_START;
      end
      ST_PTR_START: begin
        start_d  = 1'b1;
        rd_nwr_d = 1'b0;
        addr_d   = SLAVE_ADDR;
        bytes_d  = BW'(1);
        for (int i = 0; i < N; i++) din_d[i] = 8'h00;
        din_d[0] = PTR_CONV;
        state_d  = ST_PTR_WAIT;
      end
      ST_PTR_WAIT: begin
        if (i2c_transaction_done) begin
          cnt_load = 1'b1;
          state_d  = ST_CONV_DELAY;
        end
      end
      ST_CONV_DELAY: begin
        if (cnt_zero) state_d = ST_RD_START;
        else          cnt_dec = 1'b1;
      end
      ST_RD_START: begin
        start_d  = 1'b1;
        rd_nwr_d = 1'b1;
        addr_d   = SLAVE_ADDR;
        bytes_d  = BW'(2);
        for (int i = 0; i < N; i++) din_d[i] = 8'h00;
        state_d  = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        if (i2c_transaction_done) begin
          sample_d = {i2c_master_dout[0], i2c_master_dout[1]};
          valid_d  = 1'b1;
          cnt_load = 1'b1;
          state_d  = ST_CONV_DELAY;
        end
      end
      default: state_d = ST_CFG_START;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_CFG_START;
      start_q  <= 1'b0;
      rd_nwr_q <= 1'b0;
      addr_q   <= 7'h00;
      for (int i = 0; i < N; i++) din_q[i] <= 8'h00;
      bytes_q  <= '0;
      sample_q <= 16'h0000;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      start_q  <= start_d;
      rd_nwr_q <= rd_nwr_d;
      addr_q   <= addr_d;
      din_q    <= din_d;
      bytes_q  <= bytes_d;
      sample_q <= sample_d;
      valid_q  <= valid_d;
    end
  end

  // Only the first two received bytes carry the conversion result.
  always_comb begin
    dout_unused_xor = 8'h00;
    for (int i = 2; i < N; i++) dout_unused_xor = dout_unused_xor ^ i2c_master_dout[i];
  end

  assign i2c_transaction_start      = start_q;
  assign i2c_transaction_rd_nwr     = rd_nwr_q;
  assign i2c_transaction_slave_addr = addr_q;
  assign i2c_master_din             = din_q;
  assign i2c_transaction_bytes_num  = bytes_q;
  assign adc_sample                 = sample_q;
  assign adc_sample_valid           = valid_q;

endmodule

`default_nettype wire

// File: tb/tb_adc_i2c_read_fsm.sv
// ============================================================================
// Module      : tb_adc_i2c_read_fsm
// Description : Scoreboard bench for the ADC read sequencer (N=3, 10-cycle wait).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_adc_i2c_read_fsm;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        done = 1'b0;
  logic [7:0]  dout [0:2];
  logic        start;
  logic        rd_nwr;
  logic [6:0]  addr;
  logic [7:0]  din [0:2];
  logic [1:0]  bytes;
  logic [15:0] sample;
  logic        valid;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cnt = 0;
  int valid_cnt = 0;
  logic prev_start = 1'b0;
  logic prev_valid = 1'b0;

  logic [33:0] exp_txn_q [$];
  logic [15:0] exp_smp_q [$];

  adc_i2c_read_fsm #(
    .MAX_BYTES_PER_TRANSACTION (3),
    .SLAVE_ADDR                (7'h48),
    .CONFIG_WORD               (16'h8483),
    .CONV_WAIT_CYCLES          (10)
  ) dut (
    .clk                        (clk),
    .reset                      (reset),
    .i2c_transaction_done       (done),
    .i2c_master_dout            (dout),
    .i2c_transaction_start      (start),
    .i2c_transaction_rd_nwr     (rd_nwr),
    .i2c_transaction_slave_addr (addr),
    .i2c_master_din             (din),
    .i2c_transaction_bytes_num  (bytes),
    .adc_sample                 (sample),
    .adc_sample_valid           (valid)
  );

  always #4 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // {rd_nwr, bytes, addr, din[0], din[1], din[2]}
  localparam logic [33:0] TXN_CFG = {1'b0, 2'd3, 7'h48, 8'h01, 8'h84, 8'h83};
  localparam logic [33:0] TXN_PTR = {1'b0, 2'd1, 7'h48, 8'h00, 8'h00, 8'h00};
  localparam logic [33:0] TXN_RD  = {1'b1, 2'd2, 7'h48, 8'h00, 8'h00, 8'h00};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_start(input string name, input int max, output int n);
    n = 0;
    for (int i = 1; i <= max; i++) begin
      @(negedge clk);
      if (start) begin
        n = i;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL %s: no start within %0d cycles", name, max);
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, "_ctrl"}, {start, rd_nwr, addr, bytes, valid}, 64'h0);
    chk({name, "_din"}, {din[0], din[1], din[2]}, 64'h0);
    chk({name, "_sample"}, sample, 64'h0);
  endtask

  // Monitor: pops expected transactions/samples whenever the DUT presents one.
  always @(negedge clk) begin
    if (start) begin
      start_cnt++;
      checks++;
      if (exp_txn_q.size() == 0) begin
        errors++;
        $display("FAIL txn_unexpected: got %0h expected none", {rd_nwr, bytes, addr, din[0], din[1], din[2]});
      end else begin
        logic [33:0] e;
        e = exp_txn_q.pop_front();
        if ({rd_nwr, bytes, addr, din[0], din[1], din[2]} !== e) begin
          errors++;
          $display("FAIL txn: got %0h expected %0h", {rd_nwr, bytes, addr, din[0], din[1], din[2]}, e);
        end
      end
      if (prev_start) begin
        checks++;
        errors++;
        $display("FAIL start_width: got 2+ cycles expected 1");
      end
    end
    if (valid) begin
      valid_cnt++;
      checks++;
      if (exp_smp_q.size() == 0) begin
        errors++;
        $display("FAIL sample_unexpected: got %0h expected none", sample);
      end else begin
        logic [15:0] s;
        s = exp_smp_q.pop_front();
        if (sample !== s) begin
          errors++;
          $display("FAIL sample: got %0h expected %0h", sample, s);
        end
      end
      if (prev_valid) begin
        checks++;
        errors++;
        $display("FAIL valid_width: got 2+ cycles expected 1");
      end
    end
    prev_start <= start;
    prev_valid <= valid;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int c_cfg, c_ptr, c_r1, c_r2, c_r3;
    dout[0] = 8'h00; dout[1] = 8'h00; dout[2] = 8'h00;

    // 1: reset values, config transaction, nothing more while done stays low
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset1");
    exp_txn_q.push_back(TXN_CFG);
    reset = 1'b0;
    wait_start("cfg_start", 10, n);
    repeat (6) @(negedge clk);
    chk("single_start_while_busy", start_cnt, 1);

    // 2: pointer write, then the conversion delay before the first read
    exp_txn_q.push_back(TXN_PTR);
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    wait_start("ptr_start", 10, n);
    chk("ptr_latency", n, 1);
    exp_txn_q.push_back(TXN_RD);
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    if (start) begin
      n = 1;
    end else begin
      wait_start("rd_start", 30, n);
      n = n + 1;
    end
    chk("rd_start_latency", n, 12);

    // 3: positive sample, one-cycle valid, sample holds
    dout[0] = 8'h01; dout[1] = 8'h02; dout[2] = 8'h03;
    exp_smp_q.push_back(16'h0102);
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    chk("valid_latency", valid, 1);
    exp_txn_q.push_back(TXN_RD);
    @(negedge clk);
    chk("valid_one_cycle", valid, 0);
    dout[0] = 8'h55; dout[1] = 8'h66; dout[2] = 8'h77;
    repeat (4) @(negedge clk);
    chk("sample_hold_pos", sample, 16'h0102);

    // 6: negative sample
    wait_start("rd2_start", 20, n);
    dout[0] = 8'hFF; dout[1] = 8'h38; dout[2] = 8'hAA;
    exp_smp_q.push_back(16'hFF38);
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    chk("neg_sample", sample, 16'hFF38);
    exp_txn_q.push_back(TXN_RD);
    dout[0] = 8'h11; dout[1] = 8'h22;
    repeat (5) @(negedge clk);
    chk("sample_hold_neg", sample, 16'hFF38);
    chk("valid_count", valid_cnt, 2);

    // 5: reset during RD_WAIT aborts, then restart from config
    wait_start("rd3_start", 20, n);
    reset = 1'b1;
    @(negedge clk);
    chk_reset_outputs("reset_mid");
    exp_txn_q.push_back(TXN_CFG);
    reset = 1'b0;
    wait_start("restart_cfg", 10, n);
    chk("restart_cfg_latency", n, 1);

    // 4: done held high: config, pointer, then reads every 12 cycles
    reset = 1'b1;
    repeat (2) @(negedge clk);
    done = 1'b1;
    dout[0] = 8'h12; dout[1] = 8'h34; dout[2] = 8'h00;
    exp_txn_q.push_back(TXN_CFG);
    exp_txn_q.push_back(TXN_PTR);
    for (int i = 0; i < 3; i++) begin
      exp_txn_q.push_back(TXN_RD);
      exp_smp_q.push_back(16'h1234);
    end
    reset = 1'b0;
    wait_start("hi_cfg", 10, n); c_cfg = cyc;
    wait_start("hi_ptr", 10, n); c_ptr = cyc;
    wait_start("hi_rd1", 20, n); c_r1 = cyc;
    wait_start("hi_rd2", 20, n); c_r2 = cyc;
    wait_start("hi_rd3", 20, n); c_r3 = cyc;
    chk("hi_cfg_to_ptr", c_ptr - c_cfg, 2);
    chk("hi_ptr_to_rd", c_r1 - c_ptr, 12);
    chk("hi_read_period_a", c_r2 - c_r1, 12);
    chk("hi_read_period_b", c_r3 - c_r2, 12);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    done = 1'b0;
    repeat (2) @(negedge clk);
    chk("txn_queue_drained", exp_txn_q.size(), 0);
    chk("sample_queue_drained", exp_smp_q.size(), 0);
    chk("valid_total", valid_cnt, 5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
